rpi_nibble_xfer: RTL and testbench

Byte-transfer stage that consumes the 4-bit register select produced by the Pi-side select latch and moves one byte per three-strobe Pi frame between the Raspberry Pi nibble bus and the TI-side byte registers. Strobe 0 of each frame selects the register, strobe 1 carries the high nibble and strobe 2 the low nibble. The block runs entirely on the CPLD system clock and treats the Pi strobe and Pi reset as asynchronous inputs to be synchronised.

---
 rtl/rpi_nibble_xfer.sv | 152 +++++++++++++++
 tb/tb_rpi_nibble_xfer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/rpi_nibble_xfer.sv
// rpi_nibble_xfer
//   Moves one byte per three-strobe Raspberry Pi frame between the 4-bit Pi
//   nibble bus and the TI-side byte registers. Strobe 0 latches the register
//   select, strobe 1 carries the high nibble, and strobe 2 the low nibble.
//   The Pi strobe and the Pi framing reset are asynchronous to clk and are
//   synchronised here.
//
// Ports
//   clk, reset_n      system clock, synchronous active-low reset
//   rpi_clk           Pi strobe (async); a rising edge advances the frame phase
//   rpi_reset         Pi framing reset (async, active-high)
//   reg_sel[3:0]      register select, sampled on the phase-0 strobe
//   rpi_din[3:0]      nibble written by the Pi
//   rpi_dout[3:0]     nibble read by the Pi
//   td_data, tc_data  TI->Pi data/control bytes (select index 0/1)
//   rd_data, rc_data  Pi->TI data/control bytes (select index 2/3)
//   rd_wr, rc_wr      one-cycle pulse when rd_data / rc_data is updated
//   frame_err         one-cycle pulse when a frame with an illegal select ends
module rpi_nibble_xfer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rpi_clk,
  input  logic       rpi_reset,
  input  logic [3:0] reg_sel,
  input  logic [3:0] rpi_din,
  output logic [3:0] rpi_dout,
  input  logic [7:0] td_data,
  input  logic [7:0] tc_data,
  output logic [7:0] rd_data,
  output logic [7:0] rc_data,
  output logic       rd_wr,
  output logic       rc_wr,
  output logic       frame_err
);

  typedef enum logic [1:0] {PH0, PH1, PH2} phase_t;

  logic [SYNC_STAGES-1:0] clk_sync, rst_sync;
  logic                   clk_prev;
  logic                   strobe_edge, pi_rst;
  phase_t                 phase, phase_nxt;
  logic [3:0]             sel, hi_nib;
  logic                   sel_valid;
  logic [7:0]             shadow, snap;
  logic                   sel_legal, sel_write;

  // Synchronisers plus a delayed copy of the synchronised strobe for edge detect.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_sync <= '0;
      rst_sync <= '0;
      clk_prev <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], rpi_clk};
      rst_sync <= {rst_sync[SYNC_STAGES-2:0], rpi_reset};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign strobe_edge = clk_sync[SYNC_STAGES-1] & ~clk_prev;
  assign pi_rst      = rst_sync[SYNC_STAGES-1];

  // Byte a read frame would capture if this strobe were phase 0.
  assign snap      = reg_sel[0] ? tc_data : td_data;
  assign sel_legal = (sel[3:2] == 2'b00);
  assign sel_write = sel[1];

  always_ff @(posedge clk) begin
    if (!reset_n) phase <= PH0;
    else          phase <= phase_nxt;
  end

  // Pi reset wins over a coincident strobe edge.
  always_comb begin
    phase_nxt = phase;
    if (pi_rst) begin
      phase_nxt = PH0;
    end else if (strobe_edge) begin
      case (phase)
        PH0:     phase_nxt = PH1;
        PH1:     phase_nxt = PH2;
        default: phase_nxt = PH0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel       <= '0;
      sel_valid <= 1'b0;
      hi_nib    <= '0;
      shadow    <= '0;
      rpi_dout  <= '0;
      rd_data   <= '0;
      rc_data   <= '0;
      rd_wr     <= 1'b0;
      rc_wr     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rd_wr     <= 1'b0;
      rc_wr     <= 1'b0;
      frame_err <= 1'b0;
      if (pi_rst) begin
        // Drops any partial frame; target registers keep their contents.
        hi_nib    <= '0;
        sel_valid <= 1'b0;
        rpi_dout  <= '0;
      end else if (strobe_edge) begin
        case (phase)
          PH0: begin
            sel       <= reg_sel;
            sel_valid <= 1'b1;
            if (reg_sel[3:1] == 3'b000) begin
              // Snapshot keeps both nibbles of a read from the same byte.
              shadow   <= snap;
              rpi_dout <= snap[7:4];
            end else begin
              rpi_dout <= '0;
            end
          end
          PH1: begin
            if (sel_valid && sel_legal) begin
              if (sel_write) hi_nib   <= rpi_din;
              else           rpi_dout <= shadow[3:0];
            end
          end
          default: begin
            if (sel_valid) begin
              if (!sel_legal) begin
                frame_err <= 1'b1;
              end else if (sel_write) begin
                if (sel[0]) begin
                  rc_data <= {hi_nib, rpi_din};
                  rc_wr   <= 1'b1;
                end else begin
                  rd_data <= {hi_nib, rpi_din};
                  rd_wr   <= 1'b1;
                end
              end else begin
                rpi_dout <= '0;
              end
            end
            sel_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rpi_nibble_xfer.sv
module tb_rpi_nibble_xfer;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rpi_clk = 1'b0;
  logic       rpi_reset = 1'b0;
  logic [3:0] reg_sel = '0;
  logic [3:0] rpi_din = '0;
  logic [3:0] rpi_dout;
  logic [7:0] td_data = 8'h96;
  logic [7:0] tc_data = 8'h3C;
  logic [7:0] rd_data, rc_data;
  logic       rd_wr, rc_wr, frame_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rd_cnt = 0, rc_cnt = 0, fe_cnt = 0;
  int rd_cyc = 0, rc_cyc = 0;
  int rise_cyc = 0;
  int b_rd, b_rc, b_fe;

  rpi_nibble_xfer #(.SYNC_STAGES(SS)) dut (
    .clk(clk), .reset_n(reset_n), .rpi_clk(rpi_clk), .rpi_reset(rpi_reset),
    .reg_sel(reg_sel), .rpi_din(rpi_din), .rpi_dout(rpi_dout),
    .td_data(td_data), .tc_data(tc_data), .rd_data(rd_data), .rc_data(rc_data),
    .rd_wr(rd_wr), .rc_wr(rc_wr), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Pulse monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (rd_wr)     begin rd_cnt = rd_cnt + 1; rd_cyc = cyc; end
    if (rc_wr)     begin rc_cnt = rc_cnt + 1; rc_cyc = cyc; end
    if (frame_err) fe_cnt = fe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One Pi strobe; returns after the action has landed (> SS+1 cycles).
  task automatic strobe(input logic [3:0] s, input logic [3:0] d);
    @(negedge clk);
    reg_sel = s;
    rpi_din = d;
    @(negedge clk);
    rise_cyc = cyc;
    rpi_clk = 1'b1;
    repeat (SS + 2) @(negedge clk);
    rpi_clk = 1'b0;
    repeat (SS + 2) @(negedge clk);
  endtask

  initial begin
    // Reset with strobe toggling
    repeat (3) begin
      @(negedge clk);
      rpi_clk = ~rpi_clk;
    end
    rpi_clk = 1'b0;
    @(negedge clk);
    chk("rst_dout", rpi_dout, 4'h0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_rc_data", rc_data, 8'h00);
    chk("rst_pulses", {rd_wr, rc_wr, frame_err}, 3'b000);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_pulse_cnt", rd_cnt + rc_cnt + fe_cnt, 0);

    // Read TD right after reset: first edge must be phase 0
    strobe(4'h0, 4'h0);
    chk("td_hi", rpi_dout, 4'h9);
    strobe(4'h0, 4'h0);
    chk("td_lo", rpi_dout, 4'h6);
    strobe(4'h0, 4'h0);
    chk("td_end", rpi_dout, 4'h0);

    // Write RD 0xA5
    b_rd = rd_cnt; b_rc = rc_cnt;
    strobe(4'h2, 4'h0);
    chk("wr_dout0", rpi_dout, 4'h0);
    strobe(4'h2, 4'hA);
    strobe(4'h2, 4'h5);
    chk("wr_rd_data", rd_data, 8'hA5);
    chk("wr_rd_cnt", rd_cnt - b_rd, 1);
    chk("wr_rd_latency", rd_cyc - rise_cyc, SS + 1);
    chk("wr_rc_data", rc_data, 8'h00);
    chk("wr_rc_cnt", rc_cnt - b_rc, 0);

    // Read TC with a mid-frame change of tc_data
    tc_data = 8'h3C;
    strobe(4'h1, 4'h0);
    chk("tc_hi", rpi_dout, 4'h3);
    tc_data = 8'hFF;
    strobe(4'h1, 4'h0);
    chk("tc_lo", rpi_dout, 4'hC);
    strobe(4'h1, 4'h0);
    chk("tc_end", rpi_dout, 4'h0);

    // Illegal select
    b_rd = rd_cnt; b_rc = rc_cnt; b_fe = fe_cnt;
    strobe(4'h6, 4'h0);
    chk("ill_dout0", rpi_dout, 4'h0);
    strobe(4'h6, 4'hF);
    chk("ill_dout1", rpi_dout, 4'h0);
    strobe(4'h6, 4'hF);
    chk("ill_dout2", rpi_dout, 4'h0);
    chk("ill_fe_cnt", fe_cnt - b_fe, 1);
    chk("ill_wr_cnt", (rd_cnt - b_rd) + (rc_cnt - b_rc), 0);
    chk("ill_rd_data", rd_data, 8'hA5);
    chk("ill_rc_data", rc_data, 8'h00);

    // Mid-frame abort then a full RC frame
    b_rc = rc_cnt;
    strobe(4'h3, 4'h0);
    strobe(4'h3, 4'h1);
    @(negedge clk);
    rpi_reset = 1'b1;
    repeat (SS + 3) @(negedge clk);
    rpi_reset = 1'b0;
    repeat (SS + 3) @(negedge clk);
    chk("abort_rc_cnt", rc_cnt - b_rc, 0);
    chk("abort_rc_data", rc_data, 8'h00);
    strobe(4'h3, 4'h0);
    strobe(4'h3, 4'h7);
    strobe(4'h3, 4'hE);
    chk("abort_rc_data2", rc_data, 8'h7E);
    chk("abort_rc_cnt2", rc_cnt - b_rc, 1);

    // Back-to-back RD 0x12 then RC 0x34
    b_rd = rd_cnt; b_rc = rc_cnt;
    strobe(4'h2, 4'h0);
    strobe(4'h2, 4'h1);
    strobe(4'h2, 4'h2);
    strobe(4'h3, 4'h0);
    strobe(4'h3, 4'h3);
    strobe(4'h3, 4'h4);
    chk("b2b_rd_data", rd_data, 8'h12);
    chk("b2b_rc_data", rc_data, 8'h34);
    chk("b2b_pulses", (rd_cnt - b_rd) * 16 + (rc_cnt - b_rc), 17);
    // Strobe rises are 2 + 2*(SS+2) cycles apart; pulses are three strobes apart.
    chk("b2b_spacing", rc_cyc - rd_cyc, 3 * (2 + 2 * (SS + 2)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
